// File: rtl/uart_buffered_core_pkg.sv
// Shared encodings and parity helpers for the buffered UART core.
package uart_buffered_core_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_e;

    function automatic logic par_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit that brings the total count of ones to the mode's target.
    function automatic logic par_bit(input logic [1:0] mode, input logic data_xor);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; a push into an empty FIFO shows up one cycle later.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic [AW:0]      o_count
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = i_pop && (cnt_q != '0);
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_count = cnt_q;
    assign o_rdata = (cnt_q == '0) ? '0 : mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push_ok) mem_q[wptr_q] <= i_wdata;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_buffered_core.sv
// UART with run-time baud divisor and parity, RX/TX engines and FIFOs on both sides.
module uart_buffered_core
    import uart_buffered_core_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DIV_W   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic [1:0]       i_parity_mode,
    input  logic             i_rx,
    output logic             o_tx,
    input  logic [DBIT-1:0]  i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_tx_busy,
    output logic [DBIT-1:0]  o_rx_data,
    output logic             o_rx_parity_err,
    output logic             o_rx_frame_err,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic             o_rx_overrun,
    input  logic             i_clear_err
);
    localparam int SW = 6;
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] tcnt_q, div_q;
    logic             tick;

    assign tick = (tcnt_q == div_q);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tcnt_q <= '0;
            div_q  <= '0;
        end else if (tick) begin
            tcnt_q <= '0;
            div_q  <= i_divisor;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // ---------------- RX synchroniser ----------------
    logic [1:0] sync_q;
    logic       rx_prev_q, rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], i_rx};
            rx_prev_q <= rx_s;
        end
    end

    // ---------------- FIFOs ----------------
    logic [DBIT+1:0]  rx_wdata, rx_rdata;
    logic             rx_push, rx_pop, rx_full;
    logic [FIFO_AW:0] rx_count;
    logic [DBIT-1:0]  tx_rdata;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [FIFO_AW:0] tx_count;

    assign rx_pop   = o_rx_valid && i_rx_ready;
    assign tx_push  = i_tx_valid && !tx_full;
    assign tx_empty = (tx_count == '0);

    uart_sync_fifo #(.WIDTH(DBIT+2), .AW(FIFO_AW)) u_rx_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_wdata (rx_wdata),
        .i_push  (rx_push),
        .i_pop   (rx_pop),
        .o_rdata (rx_rdata),
        .o_full  (rx_full),
        .o_count (rx_count)
    );

    uart_sync_fifo #(.WIDTH(DBIT), .AW(FIFO_AW)) u_tx_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_wdata (i_tx_data),
        .i_push  (tx_push),
        .i_pop   (tx_pop),
        .o_rdata (tx_rdata),
        .o_full  (tx_full),
        .o_count (tx_count)
    );

    // ---------------- RX engine ----------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [SW-1:0]   rx_s_q, rx_s_d;
    logic [NW-1:0]   rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_b_q, rx_b_d;
    logic [1:0]      rx_mode_q, rx_mode_d;
    logic            rx_par_q, rx_par_d;
    logic            rx_perr, overrun_q;

    assign rx_perr  = par_en(rx_mode_q) && ((^rx_b_q ^ rx_par_q) != (rx_mode_q == PAR_ODD));
    assign rx_wdata = {rx_perr, !rx_s, rx_b_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_mode_d  = rx_mode_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = RX_START;
                rx_s_d     = '0;
                rx_mode_d  = i_parity_mode;
            end
            RX_START: if (tick) begin
                if (rx_s_q == S_MID) begin
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else rx_s_d = rx_s_q + 1'b1;
            end
            RX_DATA: if (tick) begin
                if (rx_s_q == S_BIT) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_s, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == N_LAST) rx_state_d = par_en(rx_mode_q) ? RX_PAR : RX_STOP;
                    else                  rx_n_d     = rx_n_q + 1'b1;
                end else rx_s_d = rx_s_q + 1'b1;
            end
            RX_PAR: if (tick) begin
                if (rx_s_q == S_BIT) begin
                    rx_s_d     = '0;
                    rx_par_d   = rx_s;
                    rx_state_d = RX_STOP;
                end else rx_s_d = rx_s_q + 1'b1;
            end
            RX_STOP: if (tick) begin
                if (rx_s_q == S_STOP) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else rx_s_d = rx_s_q + 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_state_q <= RX_IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_mode_q  <= PAR_NONE;
            rx_par_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            rx_mode_q  <= rx_mode_d;
            rx_par_q   <= rx_par_d;
            // A drop in the same cycle as a clear leaves the flag set.
            if (rx_push && rx_full && !rx_pop) overrun_q <= 1'b1;
            else if (i_clear_err)             overrun_q <= 1'b0;
        end
    end

    // ---------------- TX engine ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d;
    logic [NW-1:0]   tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_paren_q, tx_paren_d;
    logic            tx_par_q, tx_par_d;
    logic            tx_q, tx_d, tx_load;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_paren_d = tx_paren_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        tx_d       = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d    = 1'b1;
                tx_load = !tx_empty;
            end
            TX_START: begin
                tx_d = 1'b0;
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                        tx_state_d = TX_DATA;
                    end else tx_s_d = tx_s_q + 1'b1;
                end
            end
            TX_DATA: begin
                tx_d = tx_b_q[0];
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == N_LAST) tx_state_d = tx_paren_q ? TX_PAR : TX_STOP;
                        else                  tx_n_d     = tx_n_q + 1'b1;
                    end else tx_s_d = tx_s_q + 1'b1;
                end
            end
            TX_PAR: begin
                tx_d = tx_par_q;
                if (tick) begin
                    if (tx_s_q == S_BIT) begin
                        tx_s_d     = '0;
                        tx_state_d = TX_STOP;
                    end else tx_s_d = tx_s_q + 1'b1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (tx_s_q == S_STOP) begin
                        tx_state_d = TX_IDLE;
                        tx_load    = !tx_empty;
                    end else tx_s_d = tx_s_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Frame start: pop the head word and latch this frame's parity mode.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = TX_START;
            tx_s_d     = '0;
            tx_b_d     = tx_rdata;
            tx_paren_d = par_en(i_parity_mode);
            tx_par_d   = par_bit(i_parity_mode, ^tx_rdata);
        end
    end

    // o_tx follows the current state one cycle late, so it comes straight off a flop.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_paren_q <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_paren_q <= tx_paren_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx            = tx_q;
    assign o_tx_ready      = !tx_full;
    assign o_tx_busy       = (tx_state_q != TX_IDLE) || !tx_empty;
    assign o_rx_valid      = (rx_count != '0);
    assign o_rx_data       = rx_rdata[DBIT-1:0];
    assign o_rx_frame_err  = rx_rdata[DBIT];
    assign o_rx_parity_err = rx_rdata[DBIT+1];
    assign o_rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_buffered_core.sv
// Scoreboarded bench for uart_buffered_core: loopback and directly driven RX frames.
module tb_uart_buffered_core;
    localparam int DBIT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] divisor = '0;
    logic [1:0] par_mode = 2'b00;
    logic       loop = 1'b1, rx_drv = 1'b1, rx_line;
    logic       o_tx, tx_ready, tx_busy, rx_valid, rx_perr, rx_ferr, rx_overrun;
    logic [7:0] tx_data = '0, rx_data;
    logic       tx_valid = 1'b0, rx_ready = 1'b1, clear_err = 1'b0;

    int vectors = 0, miscompares = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;

    always #5 clk = ~clk;
    assign rx_line = loop ? o_tx : rx_drv;

    uart_buffered_core #(.DBIT(8), .SB_TICK(16), .DIV_W(8), .FIFO_AW(4)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_divisor(divisor), .i_parity_mode(par_mode),
        .i_rx(rx_line), .o_tx(o_tx), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_tx_busy(tx_busy), .o_rx_data(rx_data),
        .o_rx_parity_err(rx_perr), .o_rx_frame_err(rx_ferr), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .o_rx_overrun(rx_overrun), .i_clear_err(clear_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout, required event", name);
    endtask

    // Monitor: every RX handshake is checked against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_unexpected: got %0h, required none", {rx_perr, rx_ferr, rx_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_word", {22'd0, rx_perr, rx_ferr, rx_data}, {22'd0, mon_e});
            end
        end
    end

    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame on the wire, bit 0 = start bit.
    function automatic logic [31:0] ref_frame(input logic [7:0] d, input logic [1:0] m, output int nb);
        logic [31:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        nb = 9;
        if (m == 2'b01 || m == 2'b10) begin
            f[9] = (m == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
            nb = 10;
        end
        f[nb] = 1'b1;
        nb = nb + 1;
        return f;
    endfunction

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        fail("tx_write_wait");
    endtask

    task automatic wait_fall();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_tx == 1'b0) return;
        end
        fail("tx_start_wait");
    endtask

    // Called at the negedge where the start bit is first seen; samples at mid-bit (divisor 0).
    task automatic capture(input int nb, output logic [31:0] f);
        f = '0;
        repeat (8) @(negedge clk);
        f[0] = o_tx;
        for (int i = 1; i < nb; i++) begin
            repeat (16) @(negedge clk);
            f[i] = o_tx;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !rx_valid && !tx_busy) return;
        end
        fail(name);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic [1:0] m, input bit bad_par,
                           input bit stop, input int bt, input bit expect_push);
        logic p;
        int ones;
        logic perr;
        p = (^d) ^ (m == 2'b10) ^ bad_par;
        ones = $countones(d) + int'(p);
        perr = 1'b0;
        if (m == 2'b01) perr = (ones % 2 != 0);
        if (m == 2'b10) perr = (ones % 2 != 1);
        if (expect_push) exp_q.push_back({perr, !stop, d});
        rx_drv = 1'b0;
        tick_clk(bt);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick_clk(bt);
        end
        if (m == 2'b01 || m == 2'b10) begin
            rx_drv = p;
            tick_clk(bt);
        end
        rx_drv = stop;
        tick_clk(bt);
        rx_drv = 1'b1;
        tick_clk(2 * bt);
    endtask

    task automatic loop_tx_check(input logic [7:0] d, input logic [1:0] m, input string name);
        logic [31:0] got, req;
        int nb;
        req = ref_frame(d, m, nb);
        capture(nb, got);
        check(name, got, req);
    endtask

    initial begin
        logic [31:0] req;
        logic [7:0] d;
        int nb;

        tick_clk(3);
        check("rst_tx", o_tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_rx_word", {rx_perr, rx_ferr, rx_data}, 0);
        rst_n = 1'b1;
        tick_clk(4);

        // No parity, 0xA5 loopback with start latency and exact waveform.
        par_mode = 2'b00;
        exp_q.push_back({2'b00, 8'hA5});
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1", o_tx, 1);
        check("tx_busy_after_write", tx_busy, 1);
        @(negedge clk);
        check("lat_edge2", o_tx, 1);
        @(negedge clk);
        check("lat_edge3_fall", o_tx, 0);
        loop_tx_check(8'hA5, 2'b00, "frame_a5");
        wait_drain("drain_a5");

        // Even parity on TX, then a bad parity bit driven into RX.
        par_mode = 2'b01;
        exp_q.push_back({2'b00, 8'h07});
        tx_write(8'h07);
        wait_fall();
        loop_tx_check(8'h07, 2'b01, "frame_07_even");
        wait_drain("drain_07");
        loop = 1'b0;
        send_rx(8'h07, 2'b01, 1'b1, 1'b1, 16, 1'b1);
        wait_drain("drain_07_badpar");

        // Framing error, then a clean frame.
        par_mode = 2'b00;
        send_rx(8'h3C, 2'b00, 1'b0, 1'b0, 16, 1'b1);
        send_rx(8'($urandom), 2'b00, 1'b0, 1'b1, 16, 1'b1);
        wait_drain("drain_frame_err");

        // Fill the RX FIFO, overrun on the 17th word, then clear.
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_rx(8'($urandom), 2'b00, 1'b0, 1'b1, 16, i < 16);
        check("overrun_set", rx_overrun, 1);
        check("rx_valid_full", rx_valid, 1);
        clear_err = 1'b1;
        tick_clk(1);
        clear_err = 1'b0;
        check("overrun_cleared", rx_overrun, 0);
        rx_ready = 1'b1;
        wait_drain("drain_fifo16");

        // Short low glitch must not produce a word.
        rx_drv = 1'b0;
        tick_clk(4);
        rx_drv = 1'b1;
        tick_clk(64);
        check("glitch_no_word", rx_valid, 0);
        send_rx(8'h96, 2'b00, 1'b0, 1'b1, 16, 1'b1);
        wait_drain("drain_after_glitch");

        // Three back-to-back TX frames with no idle gap.
        loop = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 8'(8'h31 + 8'(i))});
        tx_write(8'h31);
        tx_write(8'h32);
        tx_write(8'h33);
        wait_fall();
        loop_tx_check(8'h31, 2'b00, "b2b_frame0");
        loop_tx_check(8'h32, 2'b00, "b2b_frame1");
        loop_tx_check(8'h33, 2'b00, "b2b_frame2");
        check("b2b_idle_after", o_tx, 1);
        wait_drain("drain_b2b");

        // Random divisor / mode loopback.
        for (int i = 0; i < 6; i++) begin
            divisor = 8'($urandom_range(0, 2));
            par_mode = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            exp_q.push_back({2'b00, d});
            tx_write(d);
            wait_drain("drain_rand_loop");
        end

        // Random directly driven frames with random parity and stop errors.
        loop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            divisor = 8'($urandom_range(0, 2));
            par_mode = 2'($urandom_range(0, 3));
            tick_clk(8);
            send_rx(8'($urandom), par_mode, 1'($urandom), 1'($urandom), 16 * (int'(divisor) + 1), 1'b1);
            wait_drain("drain_rand_rx");
        end

        // Reset in the middle of a TX and an RX frame with a word held in the RX FIFO.
        divisor = '0;
        par_mode = 2'b00;
        loop = 1'b1;
        rx_ready = 1'b0;
        tx_write(8'h11);
        tx_write(8'h22);
        wait_fall();
        repeat (160 + 4 * 16 + 8) @(negedge clk);
        check("pre_rst_rx_valid", rx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", o_tx, 1);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_tx_busy", tx_busy, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_overrun", rx_overrun, 0);
        tick_clk(2);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        tick_clk(4);
        exp_q.push_back({2'b00, 8'h5A});
        tx_write(8'h5A);
        wait_fall();
        req = ref_frame(8'h5A, 2'b00, nb);
        loop_tx_check(8'h5A, 2'b00, "frame_5a_after_rst");
        wait_drain("drain_5a");

        tick_clk(40);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
